lvds_tx_word_gen: RTL and testbench
===================================

Name: lvds_tx_word_gen

Overview:
- Parallel word source that sits directly upstream of the LVDS serializer transmit stage and drives its tx_data bus on the clkdiv-rate clock.
- After reset, emits a fixed training pattern so the far-end receiver can lock bit and word alignment.
- Afterwards, frames a valid/ready payload stream as SYNC_WORD, payload words, EOF_WORD, with IDLE_WORD filling the gaps.

Parameters:
- DATA_WIDTH, 10, word width; matches the serializer width.
- TRAIN_WORDS, 64, number of training words per training burst (≥1).
- TRAIN_PATTERN, 10'h3E0, training word (five 1s then five 0s).
- SYNC_WORD, 10'h17C, start-of-frame marker.
- EOF_WORD, 10'h283, end-of-frame marker.
- IDLE_WORD, 10'h2AA, inter-frame and underrun fill word.

Ports:
- clk  in  1  parallel-word clock (same clock as the serializer's clkdiv).
- reset  in  1  asynchronous, active-high reset.
- train_req  in  1  single-cycle pulse; requests a new training burst.
- s_data  in  DATA_WIDTH  payload word.
- s_valid  in  1  payload word valid.
- s_last  in  1  marks the final payload word of a frame.
- s_ready  out  1  payload word accepted when s_valid && s_ready.
- tx_data  out  DATA_WIDTH  registered word to the serializer.
- train_done  out  1  high while not in TRAIN.
- underrun  out  1  one-cycle pulse when IDLE_WORD is inserted mid-frame.

Behaviour:
- Clocking and reset
  - Single clock domain (clk). Reset is asynchronous and active-high.
  - All outputs are registered except s_ready, which decodes the state register directly.
  - Reset values: state = TRAIN, train counter = 0, tx_data = TRAIN_PATTERN, s_ready = 0, train_done = 0, underrun = 0, pending-train flag = 0.
- States: TRAIN, IDLE, SOF, DATA, EOF.
- TRAIN
  - tx_data = TRAIN_PATTERN every cycle.
  - Counter runs 0..TRAIN_WORDS-1.
  - On the cycle the counter reaches TRAIN_WORDS-1, go to IDLE.
  - Exactly TRAIN_WORDS training words are emitted after reset release.
  - train_req during TRAIN restarts the counter at 0.
- IDLE
  - tx_data = IDLE_WORD.
  - If the pending-train flag is set or train_req = 1: go to TRAIN, counter = 0, flag cleared.
  - Otherwise, if s_valid = 1: go to SOF.
  - train_req has priority over s_valid.
- SOF
  - tx_data = SYNC_WORD for one cycle; then go to DATA.
  - s_ready = 0 in SOF.
- DATA
  - s_ready = 1.
  - On accept: tx_data <= s_data on the next edge (one-cycle latency, no reordering).
  - No accept (s_valid = 0): tx_data <= IDLE_WORD and underrun pulses for one cycle. The frame continues.
  - Accept with s_last = 1: go to EOF.
- EOF
  - tx_data = EOF_WORD for one cycle; then go to IDLE.
  - Back-to-back frames therefore always have at least one IDLE_WORD between EOF_WORD and the next SYNC_WORD.
- s_ready is 0 in every state except DATA.
- train_req outside TRAIN and IDLE sets the pending-train flag. The current frame completes normally, and training starts on the first IDLE cycle.
- A reset asserted mid-frame aborts immediately:
  - Any partially sent frame is dropped.
  - No EOF_WORD is sent.
  - Upstream must treat the frame as lost.
- A single-word frame (s_last on the first accept) gives the sequence SYNC_WORD, word, EOF_WORD.
- The serializer stage consumes tx_data every clk cycle; this block never stalls its output.

Optional Feature:
- Macro: LVDS_TX_WORD_GEN_PRBS_EN.
- When defined:
  - In IDLE, and for the IDLE fill during a DATA underrun, tx_data carries DATA_WIDTH bits per cycle from a PRBS7 generator (x^7+x^6+1, seed 7'h7F).
  - The generator advances DATA_WIDTH steps per cycle.
  - The generator is reset to the seed by reset and holds its value outside IDLE/underrun.
  - The underrun pulse is unchanged.
- When undefined: IDLE_WORD is used as specified above, and no PRBS logic is synthesized.

Test Plan:
1. Release reset with s_valid = 0:
   - tx_data = 10'h3E0 for exactly 64 cycles, then 10'h2AA.
   - train_done rises on the first 10'h2AA cycle.
2. After training, present a 3-word frame 10'h001, 10'h002, 10'h003 (s_last on the third) with s_valid held high:
   - tx_data = 17C, 001, 002, 003, 283, 2AA.
   - s_ready is high for exactly 3 cycles.
3. Mid-frame, drop s_valid for 2 cycles:
   - Two 10'h2AA words appear between payload words.
   - underrun is high for exactly 2 cycles.
   - Word order is preserved.
4. Pulse train_req during DATA:
   - The frame finishes with 283.
   - Then 64 cycles of 3E0; a new frame is not accepted until training completes.
5. Assert reset during the second payload word:
   - tx_data = 3E0 and s_ready = 0 asynchronously.
   - Training restarts with a full 64 words.
6. With LVDS_TX_WORD_GEN_PRBS_EN defined, idle after training:
   - tx_data matches the reference PRBS7 sequence from seed 7'h7F.
   - Framing of scenario 2 is unchanged.

Source files
------------

// File: rtl/lvds_tx_word_gen.sv
// Parallel word source for the LVDS serializer: training burst after reset, then SYNC/payload/EOF framing.
// Optional PRBS7 idle fill when LVDS_TX_WORD_GEN_PRBS_EN is defined.
module lvds_tx_word_gen #(
    parameter int unsigned               DATA_WIDTH    = 10,
    parameter int unsigned               TRAIN_WORDS   = 64,
    parameter logic [DATA_WIDTH-1:0]     TRAIN_PATTERN = 10'h3E0,
    parameter logic [DATA_WIDTH-1:0]     SYNC_WORD     = 10'h17C,
    parameter logic [DATA_WIDTH-1:0]     EOF_WORD      = 10'h283,
    parameter logic [DATA_WIDTH-1:0]     IDLE_WORD     = 10'h2AA
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  train_req,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  train_done,
    output logic                  underrun
);

    localparam int unsigned      CNT_W    = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAIN_WORDS - 1);

    typedef enum logic [2:0] {
        ST_TRAIN,
        ST_IDLE,
        ST_SOF,
        ST_DATA,
        ST_EOF
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    train_done_q, train_done_d;
    logic                    underrun_q, underrun_d;
    logic                    pend_q, pend_d;
    logic [DATA_WIDTH-1:0]   word_sel;
    logic                    fill_sel;
    logic [DATA_WIDTH-1:0]   fill_word;

`ifdef LVDS_TX_WORD_GEN_PRBS_EN
    logic [6:0]              prbs_q, prbs_d, prbs_adv;
    logic [DATA_WIDTH-1:0]   prbs_word;

    // PRBS7 (x^7+x^6+1), DATA_WIDTH steps per word, first bit in the MSB
    always_comb begin
        prbs_adv  = prbs_q;
        prbs_word = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            prbs_word[DATA_WIDTH-1-i] = prbs_adv[6] ^ prbs_adv[5];
            prbs_adv                  = {prbs_adv[5:0], prbs_adv[6] ^ prbs_adv[5]};
        end
    end

    assign fill_word = prbs_word;
    assign prbs_d    = fill_sel ? prbs_adv : prbs_q;
`else
    assign fill_word = IDLE_WORD;
`endif

    // Next-state and next-word logic; the framing words trail the state by one cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        underrun_d = 1'b0;
        fill_sel   = 1'b0;
        word_sel   = IDLE_WORD;

        unique case (state_q)
            ST_TRAIN: begin
                word_sel = TRAIN_PATTERN;
                if (train_req) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_IDLE;
                    fill_sel = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (pend_q || train_req) begin
                    state_d  = ST_TRAIN;
                    cnt_d    = '0;
                    pend_d   = 1'b0;
                    word_sel = TRAIN_PATTERN;
                end else begin
                    fill_sel = 1'b1;
                    if (s_valid) begin
                        state_d = ST_SOF;
                    end
                end
            end
            ST_SOF: begin
                word_sel = SYNC_WORD;
                state_d  = ST_DATA;
                pend_d   = pend_q | train_req;
            end
            ST_DATA: begin
                pend_d = pend_q | train_req;
                if (s_valid) begin
                    word_sel = s_data;
                    if (s_last) begin
                        state_d = ST_EOF;
                    end
                end else begin
                    fill_sel   = 1'b1;
                    underrun_d = 1'b1;
                end
            end
            ST_EOF: begin
                word_sel = EOF_WORD;
                state_d  = ST_IDLE;
                pend_d   = pend_q | train_req;
            end
            default: begin
                state_d = ST_TRAIN;
                cnt_d   = '0;
            end
        endcase

        tx_data_d    = fill_sel ? fill_word : word_sel;
        train_done_d = (state_d != ST_TRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_TRAIN;
            cnt_q        <= '0;
            tx_data_q    <= TRAIN_PATTERN;
            train_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            pend_q       <= 1'b0;
`ifdef LVDS_TX_WORD_GEN_PRBS_EN
            prbs_q       <= 7'h7F;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_data_q    <= tx_data_d;
            train_done_q <= train_done_d;
            underrun_q   <= underrun_d;
            pend_q       <= pend_d;
`ifdef LVDS_TX_WORD_GEN_PRBS_EN
            prbs_q       <= prbs_d;
`endif
        end
    end

    assign s_ready    = (state_q == ST_DATA);
    assign tx_data    = tx_data_q;
    assign train_done = train_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_lvds_tx_word_gen.sv
// Scoreboard bench for lvds_tx_word_gen: frame-level stimulus pushes the expected word stream,
// a negedge monitor pops and compares one entry per cycle.
module tb_lvds_tx_word_gen;

    localparam int unsigned  DW      = 10;
    localparam logic [DW-1:0] TRAIN_W = 10'h3E0;
    localparam logic [DW-1:0] SYNC_W  = 10'h17C;
    localparam logic [DW-1:0] EOF_W   = 10'h283;
    localparam logic [DW-1:0] IDLE_W  = 10'h2AA;
    localparam int           NTRAIN  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          train_req;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [DW-1:0] tx_data;
    logic          train_done;
    logic          underrun;

    typedef struct packed {
        logic [DW-1:0] tx;
        logic          rdy;
        logic          td;
        logic          ur;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [6:0] prbs_m = 7'h7F;

    always #5 clk = ~clk;

    lvds_tx_word_gen dut (
        .clk        (clk),
        .reset      (reset),
        .train_req  (train_req),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .tx_data    (tx_data),
        .train_done (train_done),
        .underrun   (underrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [DW-1:0] tx, input logic rdy, input logic td, input logic ur);
        return {tx, rdy, td, ur};
    endfunction

    // Fill word for the next gap in the stream (fixed idle word, or next PRBS7 word)
    function automatic logic [DW-1:0] fill_word();
`ifdef LVDS_TX_WORD_GEN_PRBS_EN
        logic [DW-1:0] w;
        logic          b;
        w = '0;
        for (int i = 0; i < DW; i++) begin
            b         = prbs_m[6] ^ prbs_m[5];
            prbs_m    = {prbs_m[5:0], b};
            w[DW-1-i] = b;
        end
        return w;
`else
        return IDLE_W;
`endif
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty actual=0 required>0 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("tx_data",    32'(tx_data),    32'(e.tx));
                chk("s_ready",    32'(s_ready),    32'(e.rdy));
                chk("train_done", 32'(train_done), 32'(e.td));
                chk("underrun",   32'(underrun),   32'(e.ur));
            end
        end
    end

    // Drive one cycle of inputs and record what the DUT must show in the following cycle
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic tr, input exp_t e);
        s_valid   = v;
        s_data    = d;
        s_last    = l;
        train_req = tr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Remaining training cycles; a restart pulse at burst cycle r lengthens the burst by r+1
    task automatic train_tail(input int restart_at);
        int n;
        n = (NTRAIN - 1) + ((restart_at >= 0) ? restart_at + 1 : 0);
        for (int j = 0; j < n; j++)
            step(1'($urandom), DW'($urandom), 1'($urandom), (j == restart_at), mk(TRAIN_W, 1'b0, 1'b0, 1'b0));
        step(1'($urandom), DW'($urandom), 1'($urandom), 1'b0, mk(fill_word(), 1'b0, 1'b1, 1'b0));
        s_valid = 1'b0;
    endtask

    task automatic reset_and_train(input int restart_at);
        mon_en = 1'b0;
        exp_q.delete();
        reset     = 1'b1;
        train_req = 1'b0;
        s_last    = 1'b0;
        #1;
        chk("rst_tx_data",    32'(tx_data),    32'(TRAIN_W));
        chk("rst_s_ready",    32'(s_ready),    32'(0));
        chk("rst_train_done", 32'(train_done), 32'(0));
        chk("rst_underrun",   32'(underrun),   32'(0));
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        prbs_m = 7'h7F;
        exp_q.push_back(mk(TRAIN_W, 1'b0, 1'b0, 1'b0));
        mon_en = 1'b1;
        train_tail(restart_at);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, DW'($urandom), 1'($urandom), 1'b0, mk(fill_word(), 1'b0, 1'b1, 1'b0));
    endtask

    task automatic train_from_idle(input int restart_at);
        step(1'($urandom), DW'($urandom), 1'b0, 1'b1, mk(TRAIN_W, 1'b0, 1'b0, 1'b0));
        train_tail(restart_at);
    endtask

    // One frame starting in an IDLE cycle; treq_pos picks a frame cycle (SOF..EOF) for train_req
    task automatic send_frame(input int len, input int gap_pct, input int treq_pos, input bit seq);
        logic [DW-1:0] w[$];
        int            k;
        int            g;
        k = 0;
        for (int i = 0; i < len; i++) w.push_back(seq ? DW'(i + 1) : DW'($urandom));
        step(1'b1, w[0], 1'b0, 1'b0, mk(fill_word(), 1'b0, 1'b1, 1'b0));
        step(1'b1, w[0], 1'b0, (k == treq_pos), mk(SYNC_W, 1'b1, 1'b1, 1'b0));
        k++;
        for (int i = 0; i < len; i++) begin
            g = (int'($urandom_range(0, 99)) < gap_pct) ? int'($urandom_range(1, 2)) : 0;
            repeat (g) begin
                step(1'b0, DW'($urandom), 1'($urandom), (k == treq_pos), mk(fill_word(), 1'b1, 1'b1, 1'b1));
                k++;
            end
            step(1'b1, w[i], (i == len - 1), (k == treq_pos), mk(w[i], (i != len - 1), 1'b1, 1'b0));
            k++;
        end
        step(1'b0, DW'($urandom), 1'b0, (k == treq_pos), mk(EOF_W, 1'b0, 1'b1, 1'b0));
        k++;
        if (treq_pos >= 0 && treq_pos < k) begin
            step(1'b1, DW'($urandom), 1'b0, 1'b0, mk(TRAIN_W, 1'b0, 1'b0, 1'b0));
            train_tail(-1);
        end
    endtask

    // Reset arriving while the second payload word is on s_data
    task automatic reset_mid_frame();
        logic [DW-1:0] w0;
        w0 = DW'($urandom);
        step(1'b1, w0, 1'b0, 1'b0, mk(fill_word(), 1'b0, 1'b1, 1'b0));
        step(1'b1, w0, 1'b0, 1'b0, mk(SYNC_W, 1'b1, 1'b1, 1'b0));
        step(1'b1, w0, 1'b0, 1'b0, mk(w0, 1'b1, 1'b1, 1'b0));
        s_valid = 1'b1;
        s_data  = DW'($urandom);
        #1;
        reset_and_train(-1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int r;
        reset     = 1'b0;
        train_req = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        #2;
        reset_and_train(-1);
        idle(2);
        send_frame(3, 0, -1, 1'b1);
        idle(1);
        send_frame(4, 100, -1, 1'b0);
        send_frame(3, 0, 2, 1'b0);
        send_frame(1, 0, -1, 1'b0);
        train_from_idle(5);
        send_frame(2, 0, 0, 1'b0);
        reset_mid_frame();
        send_frame(3, 0, -1, 1'b1);
        repeat (30) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) train_from_idle((($urandom_range(0, 1)) == 0) ? -1 : int'($urandom_range(0, 63)));
            else if (r < 3) idle(int'($urandom_range(1, 3)));
            else send_frame(int'($urandom_range(1, 6)), int'($urandom_range(0, 40)),
                            ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1, 1'b0);
        end
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("queue_drain", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
